// File: rtl/or_fault_tester_if.sv
// Bus between the OR-gate self-test controller and the fault-injection harness.
// The master side is the tester; the slave side is the harness/display logic.
interface or_fault_tester_if #(
    parameter int N = 4
);
    logic                       start;
    logic                       Z;
    logic [N-1:0]               A;
    logic                       busy;
    logic                       done;
    logic [N-1:0]               sa0_in;
    logic                       sa1_any;
    logic                       z_sa0;
    logic                       fault_detected;
    logic [$clog2(N+3)-1:0]     mismatch_count;

    modport master (
        input  start,
        input  Z,
        output A,
        output busy,
        output done,
        output sa0_in,
        output sa1_any,
        output z_sa0,
        output fault_detected,
        output mismatch_count
    );

    modport slave (
        output start,
        output Z,
        input  A,
        input  busy,
        input  done,
        input  sa0_in,
        input  sa1_any,
        input  z_sa0,
        input  fault_detected,
        input  mismatch_count
    );
endinterface

// File: rtl/or_fault_tester.sv
// Self-test controller for an N-input OR gate. Applies all-zeros, a walking
// one and all-ones, samples Z after SETTLE extra cycles per pattern and
// decodes the per-pattern failures into a stuck-at diagnosis.
module or_fault_tester #(
    parameter int N      = 4,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    or_fault_tester_if.master  bus
);
    localparam int PW = $clog2(N + 2);
    localparam int CW = $clog2(N + 3);
    localparam logic [PW-1:0] LAST_P = PW'(N + 1);

    // NEXT never sits in the state register: its bookkeeping (advance the
    // pattern, clear the wait counter) happens on the sampling edge itself.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        NEXT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_r, state_n;
    logic [PW-1:0]   p_r, p_n;
    logic [3:0]      w_r, w_n;
    logic [N+1:0]    fail_r, fail_n;
    logic [CW-1:0]   cnt_r, cnt_n;
    logic [N-1:0]    a_r, a_n;
    logic            busy_r, busy_n;
    logic            done_r, done_n;
    logic [N-1:0]    sa0_r, sa0_n;
    logic            sa1_r, sa1_n;
    logic            zsa0_r, zsa0_n;
    logic            fd_r, fd_n;
    logic            mismatch_s;

    // Stimulus for pattern index p: 0 -> all zeros, 1..N -> walking one, N+1 -> all ones.
    function automatic logic [N-1:0] pattern_f(input logic [PW-1:0] p);
        logic [N-1:0] one_v;
        one_v = {{(N-1){1'b0}}, 1'b1};
        if (p == {PW{1'b0}}) begin
            pattern_f = {N{1'b0}};
        end else if (p <= PW'(N)) begin
            pattern_f = one_v << (p - PW'(1));
        end else begin
            pattern_f = {N{1'b1}};
        end
    endfunction

    // Ideal Z is 0 only for the all-zeros pattern.
    assign mismatch_s = bus.Z ^ (p_r != {PW{1'b0}});

    // Next-state and next-output logic for the test sequencer.
    always_comb begin
        state_n = state_r;
        p_n     = p_r;
        w_n     = w_r;
        fail_n  = fail_r;
        cnt_n   = cnt_r;
        a_n     = a_r;
        busy_n  = busy_r;
        done_n  = 1'b0;
        sa0_n   = sa0_r;
        sa1_n   = sa1_r;
        zsa0_n  = zsa0_r;
        fd_n    = fd_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_n = APPLY;
                    p_n     = {PW{1'b0}};
                    w_n     = 4'd0;
                    fail_n  = {(N+2){1'b0}};
                    cnt_n   = {CW{1'b0}};
                    a_n     = pattern_f({PW{1'b0}});
                    busy_n  = 1'b1;
                    sa0_n   = {N{1'b0}};
                    sa1_n   = 1'b0;
                    zsa0_n  = 1'b0;
                    fd_n    = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            APPLY: begin
                if (w_r == 4'(SETTLE)) begin
                    if (mismatch_s) begin
                        fail_n[p_r] = 1'b1;
                        cnt_n       = cnt_r + CW'(1);
                    end else begin
                        fail_n = fail_r;
                    end
                    w_n = 4'd0;
                    if (p_r == LAST_P) begin
                        state_n = DONE;
                        a_n     = {N{1'b0}};
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        sa1_n   = fail_n[0];
                        zsa0_n  = fail_n[N+1];
                        sa0_n   = fail_n[N:1] & ~{N{fail_n[N+1]}};
                        fd_n    = fail_n[0] | fail_n[N+1] | (|(fail_n[N:1] & ~{N{fail_n[N+1]}}));
                    end else begin
                        state_n = APPLY;
                        p_n     = p_r + PW'(1);
                        a_n     = pattern_f(p_r + PW'(1));
                    end
                end else begin
                    w_n = w_r + 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            NEXT: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                a_n     = {N{1'b0}};
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                a_n     = {N{1'b0}};
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            p_r     <= {PW{1'b0}};
            w_r     <= 4'd0;
            fail_r  <= {(N+2){1'b0}};
            cnt_r   <= {CW{1'b0}};
            a_r     <= {N{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sa0_r   <= {N{1'b0}};
            sa1_r   <= 1'b0;
            zsa0_r  <= 1'b0;
            fd_r    <= 1'b0;
        end else begin
            state_r <= state_n;
            p_r     <= p_n;
            w_r     <= w_n;
            fail_r  <= fail_n;
            cnt_r   <= cnt_n;
            a_r     <= a_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
            sa0_r   <= sa0_n;
            sa1_r   <= sa1_n;
            zsa0_r  <= zsa0_n;
            fd_r    <= fd_n;
        end
    end

    assign bus.A              = a_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.sa0_in         = sa0_r;
    assign bus.sa1_any        = sa1_r;
    assign bus.z_sa0          = zsa0_r;
    assign bus.fault_detected = fd_r;
    assign bus.mismatch_count = cnt_r;
endmodule

// File: tb/tb_or_fault_tester.sv
// Bench for or_fault_tester: two instances (N=4/SETTLE=2 and N=2/SETTLE=0)
// each driving a fault-injectable OR gate model.
module tb_or_fault_tester;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [3:0] sa0_a, sa1_a;
    logic       zs0_a, zs1_a;
    logic [1:0] sa0_b, sa1_b;
    logic       zs0_b, zs1_b;

    or_fault_tester_if #(.N(4)) ifa ();
    or_fault_tester_if #(.N(2)) ifb ();

    or_fault_tester #(.N(4), .SETTLE(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
    or_fault_tester #(.N(2), .SETTLE(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.master));

    // Faulty OR gates: Z stuck-at has priority over input faults.
    assign ifa.Z = zs1_a ? 1'b1 : (zs0_a ? 1'b0 : |((ifa.A & ~sa0_a) | sa1_a));
    assign ifb.Z = zs1_b ? 1'b1 : (zs0_b ? 1'b0 : |((ifb.A & ~sa0_b) | sa1_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat_f(input int n, input int p);
        logic [31:0] v;
        if (p == 0) v = 32'd0;
        else if (p <= n) v = 32'd1 << (p - 1);
        else v = (32'd1 << n) - 32'd1;
        return v[15:0];
    endfunction

    // Reference: simulate the whole run pattern by pattern, then decode.
    task automatic model(input int n, input logic [15:0] s0, input logic [15:0] s1,
                         input logic zs0, input logic zs1,
                         output logic [15:0] e_sa0, output logic e_sa1,
                         output logic e_zs0, output logic e_fd, output int e_cnt);
        bit fail[18];
        logic [15:0] mask, fi;
        bit z, ideal;
        mask  = pat_f(n, n + 1);
        e_cnt = 0;
        for (int p = 0; p < n + 2; p++) begin
            fi    = ((pat_f(n, p) & ~s0) | s1) & mask;
            z     = zs1 ? 1'b1 : (zs0 ? 1'b0 : (fi != 16'd0));
            ideal = (p != 0);
            fail[p] = (z != ideal);
            if (fail[p]) e_cnt++;
        end
        e_sa1 = fail[0];
        e_zs0 = fail[n+1];
        e_sa0 = 16'd0;
        for (int i = 0; i < n; i++) e_sa0[i] = fail[i+1] && !fail[n+1];
        e_fd = e_sa1 || e_zs0 || (e_sa0 != 16'd0);
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 0) ifa.start = v;
        else ifb.start = v;
    endtask

    task automatic get_obs(input int which, output logic [15:0] a, output logic [15:0] sa0,
                           output logic busy, output logic done, output logic sa1,
                           output logic zs0, output logic fd, output int cnt);
        if (which == 0) begin
            a = {12'd0, ifa.A}; sa0 = {12'd0, ifa.sa0_in}; busy = ifa.busy; done = ifa.done;
            sa1 = ifa.sa1_any; zs0 = ifa.z_sa0; fd = ifa.fault_detected; cnt = int'(ifa.mismatch_count);
        end else begin
            a = {14'd0, ifb.A}; sa0 = {14'd0, ifb.sa0_in}; busy = ifb.busy; done = ifb.done;
            sa1 = ifb.sa1_any; zs0 = ifb.z_sa0; fd = ifb.fault_detected; cnt = int'(ifb.mismatch_count);
        end
    endtask

    task automatic check_zero(input int which, input string tag);
        logic [15:0] a, sa0;
        logic busy, done, sa1, zs0, fd;
        int cnt;
        get_obs(which, a, sa0, busy, done, sa1, zs0, fd, cnt);
        check({tag, "_A"}, {16'd0, a}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_flags"}, {16'd0, sa0} | {29'd0, sa1, zs0, fd}, 32'd0);
        check({tag, "_cnt"}, cnt, 32'd0);
    endtask

    // One run: start accepted at edge 0; optional start re-pulse and mid-run reset.
    task automatic run(input int which, input string tag, input int restart_e, input int reset_e);
        int n, s, t, e, done_e;
        logic [15:0] a, sa0, e_sa0, d_sa0;
        logic busy, done, sa1, zs0, fd, e_sa1, e_zs0, e_fd, d_sa1, d_zs0, d_fd;
        int cnt, e_cnt, d_cnt;
        n = (which == 0) ? 4 : 2;
        s = (which == 0) ? 2 : 0;
        t = (n + 2) * (s + 1);
        if (which == 0) model(n, {12'd0, sa0_a}, {12'd0, sa1_a}, zs0_a, zs1_a, e_sa0, e_sa1, e_zs0, e_fd, e_cnt);
        else model(n, {14'd0, sa0_b}, {14'd0, sa1_b}, zs0_b, zs1_b, e_sa0, e_sa1, e_zs0, e_fd, e_cnt);
        @(negedge clk) set_start(which, 1'b1);
        @(negedge clk) set_start(which, 1'b0);
        e = 0;
        done_e = -1;
        d_sa0 = 16'd0; d_sa1 = 1'b0; d_zs0 = 1'b0; d_fd = 1'b0; d_cnt = 0;
        while (done_e < 0 && e < t + 20) begin
            get_obs(which, a, sa0, busy, done, sa1, zs0, fd, cnt);
            if (e == 0) check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
            if (e < t) check({tag, "_A_seq"}, {16'd0, a}, {16'd0, pat_f(n, e / (s + 1))});
            if (done) begin
                done_e = e;
                d_sa0 = sa0; d_sa1 = sa1; d_zs0 = zs0; d_fd = fd; d_cnt = cnt;
                check({tag, "_A_done"}, {16'd0, a}, 32'd0);
                check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
            end
            if (reset_e >= 0 && e == reset_e - 1) begin
                rst_n = 1'b0;
                #1;
                check_zero(which, {tag, "_rst"});
                @(negedge clk) rst_n = 1'b1;
                return;
            end
            if (e == restart_e - 1) set_start(which, 1'b1);
            if (e == restart_e) set_start(which, 1'b0);
            @(negedge clk);
            e++;
        end
        check({tag, "_done_edge"}, done_e, t);
        check({tag, "_sa0_in"}, {16'd0, d_sa0}, {16'd0, e_sa0});
        check({tag, "_sa1_any"}, {31'd0, d_sa1}, {31'd0, e_sa1});
        check({tag, "_z_sa0"}, {31'd0, d_zs0}, {31'd0, e_zs0});
        check({tag, "_fault"}, {31'd0, d_fd}, {31'd0, e_fd});
        check({tag, "_cnt"}, d_cnt, e_cnt);
        get_obs(which, a, sa0, busy, done, sa1, zs0, fd, cnt);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, {16'd0, sa0}, {16'd0, e_sa0});
        @(negedge clk);
    endtask

    task automatic clear_faults();
        sa0_a = 4'd0; sa1_a = 4'd0; zs0_a = 1'b0; zs1_a = 1'b0;
        sa0_b = 2'd0; sa1_b = 2'd0; zs0_b = 1'b0; zs1_b = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        clear_faults();
        repeat (3) @(negedge clk);
        check_zero(0, "reset_a");
        check_zero(1, "reset_b");
        rst_n = 1'b1;
        @(negedge clk);

        run(0, "nofault", -1, -1);
        sa0_a = 4'b0100;        run(0, "in2_sa0", -1, -1);
        clear_faults(); sa1_a = 4'b0001; run(0, "in0_sa1", -1, -1);
        clear_faults(); zs1_a = 1'b1;    run(0, "z_sa1", -1, -1);
        clear_faults(); zs0_a = 1'b1;    run(0, "z_sa0", -1, -1);
        clear_faults(); sa0_a = 4'b1111; run(0, "all_sa0", -1, -1);
        clear_faults(); sa0_b = 2'b10;   run(1, "b_in1_sa0", -1, -1);
        clear_faults(); run(0, "restart7", 7, -1);
        sa0_a = 4'b0100; run(0, "reset10", -1, 10);
        check_zero(0, "post_rst");
        clear_faults(); run(0, "clean", -1, -1);

        for (int k = 0; k < 20; k++) begin
            sa0_a = 4'($urandom_range(0, 15));
            sa1_a = 4'($urandom_range(0, 15)) & ~sa0_a;
            zs0_a = ($urandom_range(0, 7) == 0);
            zs1_a = ($urandom_range(0, 7) == 0);
            sa0_b = 2'($urandom_range(0, 3));
            sa1_b = 2'($urandom_range(0, 3)) & ~sa0_b;
            zs0_b = ($urandom_range(0, 7) == 0);
            zs1_b = ($urandom_range(0, 7) == 0);
            run(0, "rand_a", -1, -1);
            run(1, "rand_b", -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/or_fault_tester.md
# or_fault_tester

Sequential self-test controller for an N-input OR gate under stuck-at fault injection. It drives a fixed N+2 pattern sequence into the device under test, samples the device output after a programmable settle delay and compares it against the ideal OR result. At the end of the run it reports a per-line stuck-at diagnosis. It generalises the two-input OR fault check to N inputs as synthesisable RTL. It sits between the fault-injection harness and the result display/logging logic.

## Interface
- `N`, 4 — number of OR inputs under test; legal range 2..16.
- `SETTLE`, 2 — extra wait cycles per pattern before sampling `Z`; legal range 0..15.

- `clk` in 1 — single clock; all state changes on the rising edge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `start` in 1 — run request; sampled only in IDLE.
- `Z` in 1 — output of the OR gate under test.
- `A` out N — stimulus vector driven to the OR gate inputs.
- `busy` out 1 — high while patterns are being applied.
- `done` out 1 — one-cycle pulse when results become valid.
- `sa0_in` out N — bit i set: input i diagnosed stuck-at-0.
- `sa1_any` out 1 — at least one input, or Z, is stuck-at-1; the two cases are not distinguishable.
- `z_sa0` out 1 — Z is stuck-at-0, or every input is stuck-at-0; the two cases are not distinguishable.
- `fault_detected` out 1 — OR of all diagnosis flags.
- `mismatch_count` out clog2(N+3) — number of patterns whose sampled `Z` differed from the ideal value.

## Operation
- The FSM has four states: IDLE, APPLY, NEXT and DONE.
- Patterns are indexed p = 0..N+1:
  - p=0: all zeros. Ideal Z = 0.
  - p=1..N: walking one. Bit p-1 = 1, others 0. Ideal Z = 1.
  - p=N+1: all ones. Ideal Z = 1.
- IDLE → APPLY when `start`=1.
  - On that edge: p←0, wait counter w←0, internal fail vector and `mismatch_count` cleared, `A`←pattern 0.
- APPLY: w increments each cycle.
  - At the edge where w==SETTLE: sample `Z` and compare to the ideal value.
  - On mismatch: increment `mismatch_count` and set fail bit p.
  - Then go to NEXT.
- NEXT is a transient bookkeeping state taking zero extra cycles. It is merged into the sampling edge: on that same edge `A`←pattern p+1, p←p+1 and w←0. After p=N+1, go to DONE instead.
- DONE: result registers are loaded, `done`=1, `busy`=0, `A`=0. The next edge returns to IDLE.
- Result decode, applied at DONE:
  - `sa1_any` = fail[0].
  - `z_sa0` = fail[N+1].
  - `sa0_in[i]` = fail[i+1] AND NOT fail[N+1].
- Results hold until the next accepted `start`. They are cleared on that start edge.
- `start` during APPLY or DONE is ignored; no restart and no queuing.
- Multiple simultaneous flags are legal, e.g. `sa1_any` together with `sa0_in` bits under multi-fault injection.
- Under an all-inputs-SA0 fault, or under Z SA0, only `z_sa0` is reported; `sa0_in` stays 0.

## Timing
- Reset (asynchronous, immediate): FSM→IDLE; `A`=0; `busy`=0; `done`=0; `sa0_in`=0; `sa1_any`=0; `z_sa0`=0; `fault_detected`=0; `mismatch_count`=0.
- Reset mid-run aborts the run with no partial results. The first start after reset release behaves as a fresh run.
- Each pattern holds on `A` for exactly SETTLE+1 cycles.
- `Z` is sampled at the last edge of each pattern hold. The gate under test is combinational, so `Z` must be stable one cycle after `A` changes; SETTLE covers external delay.
- Let the start-accept edge be edge 0:
  - `busy` is high from edge 0.
  - `done` pulses at edge (N+2)(SETTLE+1). For N=4, SETTLE=2 that is edge 18.
  - IDLE is re-entered at edge (N+2)(SETTLE+1)+1.
- Back-to-back runs: `start` held high re-launches on the edge after DONE. Minimum run period is (N+2)(SETTLE+1)+2 cycles.
- `mismatch_count` updates live during the run. It is only valid when `done`=1 or later.

## Test plan
- No fault, N=4, SETTLE=2, start pulse at edge 0 → `done` at edge 18; all flags 0; `mismatch_count`=0; `A` sequence 0000, 0001, 0010, 0100, 1000, 1111.
- Input 2 forced SA0 → `sa0_in`=4'b0100, `sa1_any`=0, `z_sa0`=0, `mismatch_count`=1, `fault_detected`=1.
- Input 0 forced SA1 → `sa1_any`=1, `sa0_in`=0, `mismatch_count`=1. Repeat with Z forced SA1 → identical result.
- Z forced SA0 → `z_sa0`=1, `sa0_in`=0, `mismatch_count`=5. Repeat with all four inputs forced SA0 → identical result.
- N=2, SETTLE=0, input 1 SA0 → `done` at edge 4, `sa0_in`=2'b10, `mismatch_count`=1.
- `start` re-pulsed at edge 7 → ignored, `done` still at edge 18. `rst_n` low at edge 10 → all outputs 0 immediately. Next start → clean run with fault-free results.
